// File: rtl/ntsc_pkg.sv
// Shared constants, fetch-state enum and line-address helper for the NTSC line fetcher.
// The optional underrun statistics counter is enabled by NTSC_FETCH_STATS_EN.
package ntsc_pkg;

  localparam int H_RES          = 560;
  localparam int ROWS           = 200;
  localparam int PIX_PER_WORD   = 4;
  localparam int WORDS_PER_LINE = H_RES / PIX_PER_WORD;
  localparam int ADDR_W         = 18;

  localparam logic [7:0] SIGNAL_LEVEL_SYNC  = 8'd0;
  localparam logic [7:0] SIGNAL_LEVEL_BLANK = 8'd72;
  localparam logic [7:0] SIGNAL_LEVEL_BLACK = 8'd82;
  localparam logic [7:0] SIGNAL_LEVEL_WHITE = 8'd255;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } fetch_state_e;

  // line * 140 built from shifts: 140 = 128 + 8 + 4
  function automatic logic [ADDR_W-1:0] lineBase(input logic [8:0] line);
    logic [ADDR_W-1:0] l;
    l = ADDR_W'(line);
    return (l << 7) + (l << 3) + (l << 2);
  endfunction

endpackage

// File: rtl/ntsc_line_ram.sv
// Two-bank line buffer: writes four 4-bit pixels per memory word, one registered pixel read.
module ntsc_line_ram
  import ntsc_pkg::*;
(
  input  logic        clk_i,
  input  logic        wrEn_i,
  input  logic        wrBank_i,
  input  logic [7:0]  wrWord_i,
  input  logic [15:0] wrData_i,
  input  logic        rdBank_i,
  input  logic [9:0]  rdX_i,
  output logic [3:0]  rdData_o
);

  logic [3:0] mem [2][H_RES];

  always_ff @(posedge clk_i) begin
    if (wrEn_i) begin
      for (int k = 0; k < PIX_PER_WORD; k++) begin
        mem[wrBank_i][{wrWord_i, 2'(k)}] <= wrData_i[4*k +: 4];
      end
    end
    rdData_o <= mem[rdBank_i][rdX_i];
  end

endmodule

// File: rtl/ntsc_line_fetch.sv
// Prefetches one display row per scanline into a ping-pong line buffer and serves pixels.
// Defining NTSC_FETCH_STATS_EN adds a saturating underrun_count_o output.
module ntsc_line_fetch
  import ntsc_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              h_sync_i,
  input  logic              v_sync_i,
  input  logic              pixel_is_visible_i,
  input  logic [10:0]       pixel_x_i,
  input  logic [10:0]       pixel_y_i,
  output logic [3:0]        pixel_data_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [15:0]       mem_rdata_i,
  output logic              underrun_o
`ifdef NTSC_FETCH_STATS_EN
  ,
  output logic [7:0]        underrun_count_o
`endif
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              bank_q, bank_d;
  logic [7:0]        wordCnt_q, wordCnt_d;
  logic [1:0]        valid_q, valid_d;
  logic              underrun_q, underrun_d;
  logic              field_q, field_d;
  logic              visible_q;
  logic              pixSel_q, pixSel_d;

  logic [9:0]        dispRow;
  logic              dispBank, xInRange, fallTrig, trig;
  logic [7:0]        newRow;
  logic [8:0]        newLine;
  logic [ADDR_W-1:0] newBase;
  logic              newBank;
  logic              wrEn, collide, readUnderrun;
  logic [3:0]        ramData;
  logic              unusedInputs;

  assign unusedInputs = ^{h_sync_i, pixel_y_i[0]};

  assign dispRow  = pixel_y_i[10:1];
  assign dispBank = dispRow[0];
  assign xInRange = pixel_x_i < 11'(H_RES);
  assign fallTrig = visible_q && !pixel_is_visible_i && (dispRow < 10'(ROWS - 1));
  assign trig     = v_sync_i || fallTrig;
  assign newRow   = v_sync_i ? 8'd0 : 8'(dispRow + 10'd1);
  assign newLine  = {newRow, field_d};
  assign newBase  = lineBase(newLine);
  assign newBank  = newRow[0];

  assign readUnderrun = pixel_is_visible_i && xInRange && !valid_q[dispBank];
  assign pixSel_d     = pixel_is_visible_i && xInRange && valid_q[dispBank];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      base_q     <= '0;
      bank_q     <= 1'b0;
      wordCnt_q  <= '0;
      valid_q    <= '0;
      underrun_q <= 1'b0;
      field_q    <= 1'b0;
      visible_q  <= 1'b0;
      pixSel_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      base_q     <= base_d;
      bank_q     <= bank_d;
      wordCnt_q  <= wordCnt_d;
      valid_q    <= valid_d;
      underrun_q <= underrun_d;
      field_q    <= field_d;
      visible_q  <= pixel_is_visible_i;
      pixSel_q   <= pixSel_d;
    end
  end

  // A trigger while busy retargets the fetch; the outstanding word is drained and dropped
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    base_d     = base_q;
    bank_d     = bank_q;
    wordCnt_d  = wordCnt_q;
    valid_d    = valid_q;
    field_d    = v_sync_i ? !field_q : field_q;
    wrEn       = 1'b0;
    collide    = 1'b0;

    case (state_q)
      IDLE: begin
        if (trig) begin
          state_d          = FETCH;
          addr_d           = newBase;
          base_d           = newBase;
          bank_d           = newBank;
          wordCnt_d        = '0;
          valid_d[newBank] = 1'b0;
        end
      end
      FETCH: begin
        if (trig) begin
          base_d           = newBase;
          bank_d           = newBank;
          valid_d[newBank] = 1'b0;
          collide          = !v_sync_i;
          if (mem_ack_i) begin
            addr_d    = newBase;
            wordCnt_d = '0;
          end else begin
            state_d = DRAIN;
          end
        end else if (mem_ack_i) begin
          wrEn = 1'b1;
          if (wordCnt_q == 8'(WORDS_PER_LINE - 1)) begin
            state_d         = IDLE;
            valid_d[bank_q] = 1'b1;
          end else begin
            wordCnt_d = wordCnt_q + 8'd1;
            addr_d    = addr_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (trig) begin
          base_d           = newBase;
          bank_d           = newBank;
          valid_d[newBank] = 1'b0;
          collide          = !v_sync_i;
        end
        if (mem_ack_i) begin
          state_d   = FETCH;
          addr_d    = trig ? newBase : base_q;
          wordCnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    underrun_d = underrun_q || collide || readUnderrun;
  end

  ntsc_line_ram u_ram (
    .clk_i    (clk_i),
    .wrEn_i   (wrEn),
    .wrBank_i (bank_q),
    .wrWord_i (wordCnt_q),
    .wrData_i (mem_rdata_i),
    .rdBank_i (dispBank),
    .rdX_i    (xInRange ? pixel_x_i[9:0] : 10'd0),
    .rdData_o (ramData)
  );

  assign pixel_data_o = pixSel_q ? ramData : 4'd0;
  assign mem_req_o    = (state_q != IDLE);
  assign mem_addr_o   = addr_q;
  assign underrun_o   = underrun_q;

`ifdef NTSC_FETCH_STATS_EN
  logic [7:0] underrunCount_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      underrunCount_q <= '0;
    end else if ((collide || readUnderrun) && underrunCount_q != 8'hFF) begin
      underrunCount_q <= underrunCount_q + 8'd1;
    end
  end

  assign underrun_count_o = underrunCount_q;
`endif

endmodule
